// File: rtl/uart_fsm_receiver_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver slice.
//   uart_rx_state_t : receiver FSM states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS  : payload bits per frame (8N1)
//   uart_cnt_width  : width of the per-bit clock counter for a given
//                     CLKS_PER_BIT ($clog2(CLKS_PER_BIT)+1)
// Optional feature macro used by importers: UART_RX_FRAME_ERR_EN
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int uart_cnt_width(input int clks);
        return $clog2(clks) + 1;
    endfunction

endpackage

// File: rtl/uart_fsm_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_fsm_receiver_if
// Bundles the serial input and the byte-wide result of the receiver.
//   d         : serial line, idle high (driven by the line / transmitter)
//   done      : one-cycle strobe, a valid byte was captured
//   dout      : last received byte
//   frame_err : one-cycle strobe on a bad stop bit (only when
//               UART_RX_FRAME_ERR_EN is defined)
// Modports:
//   master : the receiver (samples d, drives done/dout/frame_err)
//   slave  : the line driver / byte consumer
// ---------------------------------------------------------------------------
interface uart_fsm_receiver_if import uart_pkg::*; ();

    logic                      d;
    logic                      done;
    logic [UART_DATA_BITS-1:0] dout;
`ifdef UART_RX_FRAME_ERR_EN
    logic                      frame_err;

    modport master (input d, output done, output dout, output frame_err);
    modport slave  (output d, input done, input dout, input frame_err);
`else
    modport master (input d, output done, output dout);
    modport slave  (output d, input done, input dout);
`endif

endinterface

// File: rtl/uart_fsm_receiver_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Mid-bit / full-bit tick generator for the UART receiver.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   clear     : restart the bit-time count from zero on the next edge
//   mid_tick  : counter is at CLKS_PER_BIT/2-1 (middle of a bit)
//   full_tick : counter is at CLKS_PER_BIT-1 (end of a bit time)
// With CLKS_PER_BIT=1 the counter is removed: every clock is a full bit,
// so full_tick is constant 1 and mid_tick is never used.
// ---------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic mid_tick,
    output logic full_tick
);

    generate
        if (CLKS_PER_BIT == 1) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = clk ^ rst ^ clear;
            assign mid_tick      = 1'b0;
            assign full_tick     = 1'b1;
        end else begin : g_count
            localparam int CNT_W = uart_cnt_width(CLKS_PER_BIT);
            localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
            localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

            logic [CNT_W-1:0] clk_cnt_reg;

            // Wraps to zero at every bit boundary; clear re-phases the
            // count so that later full ticks land mid-bit.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    clk_cnt_reg <= '0;
                end else if (clear || (clk_cnt_reg == FULL_CNT)) begin
                    clk_cnt_reg <= '0;
                end else begin
                    clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                end
            end

            assign mid_tick  = (clk_cnt_reg == MID_CNT);
            assign full_tick = (clk_cnt_reg == FULL_CNT);
        end
    endgenerate

endmodule

// File: rtl/uart_fsm_receiver.sv
// ---------------------------------------------------------------------------
// uart_fsm_receiver
// 8N1 serial-to-parallel UART receiver. Detects a start bit on bus.d,
// shifts in 8 data bits LSB first, checks the stop bit and presents the
// byte on bus.dout with a one-cycle bus.done strobe.
//   CLKS_PER_BIT : clocks per bit time (1, or 2..65535)
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : uart_fsm_receiver_if.master (d in; done, dout out)
// Optional: define UART_RX_FRAME_ERR_EN to add bus.frame_err, a one-cycle
// strobe raised when the stop bit is sampled low.
// ---------------------------------------------------------------------------
module uart_fsm_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_fsm_receiver_if.master        bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;

    // One clock per bit: the start bit is taken at face value and the
    // bit timer is bypassed.
    localparam bit SINGLE_CLK = (CLKS_PER_BIT == 1);

    logic [1:0]                state_reg,   state_next;
    logic [2:0]                bit_cnt_reg, bit_cnt_next;
    logic [UART_DATA_BITS-1:0] shift_reg,   shift_next;
    logic [UART_DATA_BITS-1:0] dout_reg,    dout_next;
    logic                      done_reg,    done_next;
`ifdef UART_RX_FRAME_ERR_EN
    logic                      frame_err_reg, frame_err_next;
`endif

    logic timer_clear;
    logic mid_tick;
    logic full_tick;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .mid_tick  (mid_tick),
        .full_tick (full_tick)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        dout_next    = dout_reg;
        done_next    = 1'b0;
        timer_clear  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frame_err_next = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Hold the timer at zero so START counts from the edge
                // that first saw the line low.
                timer_clear = 1'b1;
                if (!bus.d) begin
                    bit_cnt_next = '0;
                    state_next   = SINGLE_CLK ? ST_DATA : ST_START;
                end
            end
            ST_START: begin
                if (mid_tick) begin
                    // Re-phase: later full ticks fall in mid-bit.
                    timer_clear  = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = bus.d ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_tick) begin
                    shift_next   = {bus.d, shift_reg[UART_DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (full_tick) begin
                    if (bus.d) begin
                        dout_next = shift_reg;
                        done_next = 1'b1;
                    end else begin
`ifdef UART_RX_FRAME_ERR_EN
                        frame_err_next = 1'b1;
`endif
                    end
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            dout_reg    <= '0;
            done_reg    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            dout_reg    <= dout_next;
            done_reg    <= done_next;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_reg <= frame_err_next;
`endif
        end
    end

    assign bus.done = done_reg;
    assign bus.dout = dout_reg;
`ifdef UART_RX_FRAME_ERR_EN
    assign bus.frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_uart_fsm_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_fsm_receiver
// Drives two receivers (CLKS_PER_BIT=1 and 16) with directed and random
// 8N1 frames. A frame-level reference model predicts, for every frame,
// the cycle where done must rise and the byte that must appear on dout;
// done and dout are compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_uart_fsm_receiver;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         good;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    bit   mon_en;
    int   n_checks;
    int   n_fail;

    exp_t       q1[$];
    exp_t       q16[$];
    logic [7:0] last_dout [2];

    uart_fsm_receiver_if rx1_if ();
    uart_fsm_receiver_if rx16_if ();

    uart_fsm_receiver #(.CLKS_PER_BIT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (rx1_if)
    );

    uart_fsm_receiver #(.CLKS_PER_BIT(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (rx16_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle comparison for one receiver against its expected frames.
    task automatic mon(input int sel, input logic done_o, input logic [7:0] dout_o);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (sel == 0 && q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        if (sel == 1 && q16.size() > 0 && q16[0].due == cyc) begin
            e = q16.pop_front();
            have = 1'b1;
        end
        if (have) begin
            if (e.good) last_dout[sel] = e.data;
            check($sformatf("done_at_stop%0d", sel), {31'd0, done_o}, {31'd0, e.good});
`ifdef UART_RX_FRAME_ERR_EN
            check($sformatf("frame_err%0d", sel),
                  {31'd0, (sel == 0) ? rx1_if.frame_err : rx16_if.frame_err},
                  {31'd0, !e.good});
`endif
            $display("rx%0d frame data=%02h stop=%0d done=%0b dout=%02h cycle=%0d",
                     sel, e.data, e.good, done_o, dout_o, cyc);
        end else begin
            check($sformatf("done_idle%0d", sel), {31'd0, done_o}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
            check($sformatf("frame_err_idle%0d", sel),
                  {31'd0, (sel == 0) ? rx1_if.frame_err : rx16_if.frame_err}, 32'd0);
`endif
        end
        check($sformatf("dout%0d", sel), {24'd0, dout_o}, {24'd0, last_dout[sel]});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, rx1_if.done, rx1_if.dout);
            mon(1, rx16_if.done, rx16_if.dout);
        end
    end

    task automatic set_d(input int sel, input logic v);
        if (sel == 0) rx1_if.d = v;
        else          rx16_if.d = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Sends start, 8 data bits LSB first, stop, then `gap` idle clocks.
    // Called at posedge+2, so the next edge is the start-bit edge.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic stop_bit, input int gap);
        int         cpb;
        exp_t       e;
        logic [9:0] bits;
        cpb    = (sel == 0) ? 1 : 16;
        bits   = {stop_bit, data, 1'b0};
        e.due  = cyc + 1 + cpb / 2 + 9 * cpb;
        e.data = data;
        e.good = stop_bit;
        if (sel == 0) q1.push_back(e);
        else          q16.push_back(e);
        for (int i = 0; i < 10; i++) begin
            set_d(sel, bits[i]);
            idle(cpb);
        end
        set_d(sel, 1'b1);
        if (gap > 0) idle(gap);
    endtask

    task automatic glitch16(input int len);
        set_d(1, 1'b0);
        idle(len);
        set_d(1, 1'b1);
        idle(32);
    endtask

    task automatic mid_frame_reset(input logic [7:0] data);
        set_d(0, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            set_d(0, data[i]);
            idle(1);
        end
        rst = 1'b0;
        set_d(0, 1'b1);
        last_dout[0] = 8'h00;
        last_dout[1] = 8'h00;
        $display("rx0 mid-frame reset asserted cycle=%0d", cyc);
        idle(3);
        rst = 1'b1;
        idle(3);
    endtask

    initial begin
        int   gap;
        logic stop_bit;
        n_checks     = 0;
        n_fail       = 0;
        mon_en       = 1'b0;
        rst          = 1'b0;
        rx1_if.d     = 1'b1;
        rx16_if.d    = 1'b1;
        last_dout[0] = 8'h00;
        last_dout[1] = 8'h00;

        // Reset held with the line idle, then released with no traffic.
        idle(2);
        mon_en = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(5);

        // Directed frames at one clock per bit.
        send_frame(0, 8'hAB, 1'b1, 3);
        send_frame(0, 8'h5A, 1'b0, 2);
        send_frame(0, 8'h3C, 1'b1, 2);
        send_frame(0, 8'hAB, 1'b1, 0);
        send_frame(0, 8'h01, 1'b1, 3);
        mid_frame_reset(8'h96);
        send_frame(0, 8'hFF, 1'b1, 3);

        // Directed frames at sixteen clocks per bit.
        glitch16(4);
        send_frame(1, 8'hC3, 1'b1, 5);
        send_frame(1, 8'h77, 1'b0, 32);
        send_frame(1, 8'h18, 1'b1, 0);

        // Random traffic, one clock per bit.
        for (int i = 0; i < 40; i++) begin
            stop_bit = ($urandom_range(0, 6) != 0);
            gap      = $urandom_range(0, 3);
            send_frame(0, 8'($urandom), stop_bit, gap);
        end

        // Random traffic with start glitches, sixteen clocks per bit.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) glitch16($urandom_range(1, 7));
            stop_bit = ($urandom_range(0, 4) != 0);
            gap      = stop_bit ? $urandom_range(0, 20) : 32;
            send_frame(1, 8'($urandom), stop_bit, gap);
        end

        // Every predicted frame must have been reached by the monitor.
        for (int i = 0; i < 2000; i++) begin
            if (q1.size() == 0 && q16.size() == 0) break;
            idle(1);
        end
        check("drain", q1.size() + q16.size(), 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
